btn_repeat_pulse: RTL and testbench

//  Front-end conditioner for one raw push-button feeding the timer's min/sec

---
 rtl/btn_repeat_pulse.sv | 123 ++++++++++++
 tb/tb_btn_repeat_pulse.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_repeat_pulse.sv
// Push-button conditioner: synchroniser, debouncer and press/auto-repeat pulse FSM.
// One instance per button; all outputs registered in the clk domain.
`timescale 1ns/1ps
module btn_repeat_pulse #(
    parameter int SYNC_STAGES   = 2,
    parameter int DEB_CYCLES    = 1_000_000,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb,
    input  logic rep_en,
    output logic pb_level,
    output logic pulse,
    output logic is_repeat,
    output logic held
);
    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW   = $clog2(DEB_CYCLES + 1);
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REPEAT} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pb_s;
    logic [CW-1:0]          deb_cnt;
    logic                   deb_hit;
    logic                   level_keep;
    state_t                 state;
    logic [TW-1:0]          timer;

    assign pb_s    = sync_q[SYNC_STAGES-1];
    assign deb_hit = (pb_s != pb_level) && (deb_cnt == DEB_LAST);
    // Level as it will be after this edge: lets a release win over a repeat due on the same edge.
    assign level_keep = pb_level && !deb_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pb};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pb_level <= 1'b0;
            deb_cnt  <= '0;
        end else if (pb_s == pb_level) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            pb_level <= pb_s;
            deb_cnt  <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            timer     <= '0;
            pulse     <= 1'b0;
            is_repeat <= 1'b0;
            held      <= 1'b0;
        end else begin
            pulse     <= 1'b0;
            is_repeat <= 1'b0;
            if (!level_keep) begin
                state <= S_IDLE;
                timer <= '0;
                held  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        pulse <= 1'b1;
                        timer <= '0;
                        held  <= 1'b0;
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        held <= 1'b0;
                        if (timer != HOLD_LAST) begin
                            timer <= timer + 1'b1;
                        end else if (rep_en) begin
                            pulse     <= 1'b1;
                            is_repeat <= 1'b1;
                            timer     <= '0;
                            state     <= S_REPEAT;
                        end
                    end
                    S_REPEAT: begin
                        if (!rep_en) begin
                            // Parked at the hold limit so re-enabling repeats on the next edge.
                            state <= S_WAIT;
                            timer <= HOLD_LAST;
                            held  <= 1'b0;
                        end else begin
                            held <= 1'b1;
                            if (timer == REP_LAST) begin
                                pulse     <= 1'b1;
                                is_repeat <= 1'b1;
                                timer     <= '0;
                            end else begin
                                timer <= timer + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        timer <= '0;
                        held  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_btn_repeat_pulse.sv
// Bench for btn_repeat_pulse: countdown-style reference model feeds a pulse
// scoreboard, plus directed pulse-timing lists for the hand-derived scenarios.
`timescale 1ns/1ps
module tb_btn_repeat_pulse;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic pb     = 1'b0;
    logic rep_en = 1'b0;
    logic pb_level, pulse, is_repeat, held;

    btn_repeat_pulse #(
        .SYNC_STAGES  (SYNC),
        .DEB_CYCLES   (DEB),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pb       (pb),
        .rep_en   (rep_en),
        .pb_level (pb_level),
        .pulse    (pulse),
        .is_repeat(is_repeat),
        .held     (held)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int   cyc;
        logic rep;
    } pexp_t;

    pexp_t exp_q[$];

    // reference model state
    logic [SYNC-1:0] m_sync;
    logic m_lvl, m_active, m_inrep, m_held;
    int   m_run, m_due, m_pulses;

    int   abs_cyc = 0;
    int   cyc = 0;
    int   obs[$];
    int   want[$];
    int   dut_pulses = 0;
    int   held_first, lvl_first;
    logic prev_pulse;
    logic lvl_seen;

    task automatic model_reset();
        m_sync   = '0;
        m_lvl    = 1'b0;
        m_run    = 0;
        m_active = 1'b0;
        m_inrep  = 1'b0;
        m_held   = 1'b0;
        m_due    = 0;
        prev_pulse = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_edge(input logic pb_in, input logic re_in);
        logic  pbs, lvl_old;
        pexp_t e;
        pbs     = m_sync[SYNC-1];
        lvl_old = m_lvl;
        e.cyc   = abs_cyc;
        e.rep   = 1'b0;
        if (pbs == m_lvl) begin
            m_run = 0;
        end else begin
            m_run++;
            if (m_run == DEB) begin
                m_lvl = pbs;
                m_run = 0;
            end
        end
        m_sync = {m_sync[SYNC-2:0], pb_in};
        if (!m_lvl) begin
            m_active = 1'b0;
            m_inrep  = 1'b0;
            m_held   = 1'b0;
        end else if (!m_active) begin
            m_held = 1'b0;
            if (lvl_old) begin
                m_active = 1'b1;
                m_due    = HOLD;
                exp_q.push_back(e);
                m_pulses++;
            end
        end else if (m_inrep && !re_in) begin
            m_inrep = 1'b0;
            m_due   = 1;
            m_held  = 1'b0;
        end else begin
            m_held = m_inrep;
            if (m_due > 1) begin
                m_due--;
            end else if (re_in) begin
                m_due   = REP;
                m_inrep = 1'b1;
                e.rep   = 1'b1;
                exp_q.push_back(e);
                m_pulses++;
            end
        end
    endtask

    task automatic step();
        logic  pb_in, re_in, rst_in, exp_now;
        pexp_t e;
        pb_in  = pb;
        re_in  = rep_en;
        rst_in = rst_n;
        @(posedge clk);
        #1;
        abs_cyc++;
        cyc++;
        if (!rst_in) model_reset();
        else model_edge(pb_in, re_in);
        check("pb_level", int'(pb_level), int'(m_lvl));
        check("held", int'(held), int'(m_held));
        exp_now = (exp_q.size() > 0) && (exp_q[0].cyc == abs_cyc);
        check("pulse", int'(pulse), int'(exp_now));
        if (exp_now) begin
            e = exp_q.pop_front();
            check("is_repeat", int'(is_repeat), int'(e.rep));
        end else begin
            check("is_repeat_idle", int'(is_repeat), 0);
        end
        check("back_to_back", int'(pulse && prev_pulse), 0);
        check("pulse_lvl0", int'(pulse && !pb_level), 0);
        if (pulse) begin
            obs.push_back(cyc);
            dut_pulses++;
        end
        if (held && held_first < 0) held_first = cyc;
        if (pb_level && lvl_first < 0) lvl_first = cyc;
        if (pb_level) lvl_seen = 1'b1;
        prev_pulse = pulse;
    endtask

    task automatic start_test();
        cyc        = 0;
        held_first = -1;
        lvl_first  = -1;
        lvl_seen   = 1'b0;
        obs.delete();
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_count"}, obs.size(), want.size());
        for (int i = 0; i < obs.size() && i < want.size(); i++)
            check($sformatf("%s_%0d", tag, i), obs[i], want[i]);
    endtask

    task automatic release_idle();
        pb = 1'b0;
        repeat (15) step();
    endtask

    initial begin
        int base;
        model_reset();
        m_pulses = 0;
        start_test();
        #1 rst_n = 1'b0;
        #1;
        check("rst_pb_level", int'(pb_level), 0);
        check("rst_pulse", int'(pulse), 0);
        check("rst_is_repeat", int'(is_repeat), 0);
        check("rst_held", int'(held), 0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) step();

        // clean press held with repeat enabled
        start_test();
        rep_en = 1'b1;
        pb = 1'b1;
        repeat (30) step();
        want = '{7, 17, 20, 23, 26, 29};
        compare_log("t1_pulses");
        check("t1_lvl_at", lvl_first, 6);
        check("t1_held_from", held_first, 18);
        release_idle();

        // short glitch must not register
        start_test();
        pb = 1'b1;
        repeat (3) step();
        pb = 1'b0;
        repeat (12) step();
        check("t2_glitch_lvl", int'(lvl_seen), 0);
        want = {};
        compare_log("t2_glitch_pulses");

        // bounce 1,0,1 then stable
        start_test();
        rep_en = 1'b0;
        pb = 1'b1; step();
        pb = 1'b0; step();
        pb = 1'b1;
        repeat (20) step();
        want = '{9};
        compare_log("t2_bounce_pulses");
        release_idle();

        // repeat disabled, then enabled mid-hold
        start_test();
        rep_en = 1'b0;
        pb = 1'b1;
        repeat (30) step();
        want = '{7};
        compare_log("t3_norep_pulses");
        check("t3_held_never", held_first, -1);
        rep_en = 1'b1;
        repeat (10) step();
        want = '{7, 31, 34, 37, 40};
        compare_log("t3_rep_pulses");
        check("t3_held_from", held_first, 32);
        release_idle();

        // release lands on the edge a repeat is due
        start_test();
        pb = 1'b1;
        repeat (20) step();
        pb = 1'b0;
        repeat (6) step();
        check("t4_lvl", int'(pb_level), 0);
        check("t4_pulse", int'(pulse), 0);
        check("t4_held", int'(held), 0);
        repeat (10) step();
        want = '{7, 17, 20, 23};
        compare_log("t4_pulses");

        // reset while in repeat with button still pressed
        start_test();
        pb = 1'b1;
        repeat (21) step();
        check("t5_held_before", int'(held), 1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("t5_rst_pb_level", int'(pb_level), 0);
        check("t5_rst_pulse", int'(pulse), 0);
        check("t5_rst_is_repeat", int'(is_repeat), 0);
        check("t5_rst_held", int'(held), 0);
        repeat (2) step();
        rst_n = 1'b1;
        start_test();
        repeat (10) step();
        want = '{7};
        compare_log("t5_pulses");
        check("t5_lvl_at", lvl_first, 6);
        release_idle();

        // random bursts against the model
        base = dut_pulses;
        m_pulses = 0;
        for (int b = 0; b < 60; b++) begin
            pb = 1'($urandom_range(0, 1));
            rep_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(20, 45)) step();
            else repeat ($urandom_range(1, 8)) step();
        end
        release_idle();
        check("t6_pulse_total", dut_pulses - base, m_pulses);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
